// File: rtl/uart_cmd_parser_pkg.sv
// Shared types, ASCII constants and hex helpers for the inbound debug command parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEP1,
        ST_ADDR,
        ST_SEP2,
        ST_DATA,
        ST_ISSUE,
        ST_DISCARD
    } state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_W_UC = 8'h57;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_R_UC = 8'h52;
    localparam logic [7:0] ASCII_R_LC = 8'h72;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    // Inverse of the logger's nibble-to-ASCII encoder; only meaningful when is_hex(b).
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        logic [7:0] t;
        if (b <= 8'h39)      t = b - 8'h30;
        else if (b <= 8'h46) t = b - 8'h37;
        else                 t = b - 8'h57;
        return t[3:0];
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Request channel from the command parser to the memory/debug bus.
interface uart_cmd_parser_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    modport master (output cmd_valid, cmd_write, cmd_addr, cmd_wdata, input cmd_ready);
    modport slave  (input cmd_valid, cmd_write, cmd_addr, cmd_wdata, output cmd_ready);
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses ASCII "W addr data" / "R addr" lines from the UART receiver into one
// bus request per line, with error pulses for malformed lines, overruns and timeouts.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 27,
    parameter int TIMEOUT_MS = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    uart_cmd_parser_if.master         cmd,
    output logic                      err,
    output logic                      busy
);

    localparam longint     LIMIT    = longint'(CLK_FREQ) * 64'd1000 * longint'(TIMEOUT_MS);
    localparam bit         TMO_EN   = (TIMEOUT_MS > 0);
    localparam logic [31:0] LIMIT_M1 = TMO_EN ? 32'(LIMIT - 64'd1) : 32'd0;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        vld_q, vld_d;
    logic [31:0] timer_q, timer_d;

    logic       active, timeout;
    logic       hex, term, sp, cnt_ok, has_dig, bad;
    logic [3:0] nib;

    assign active = (state_q == ST_SEP1) || (state_q == ST_ADDR) || (state_q == ST_SEP2) ||
                    (state_q == ST_DATA) || (state_q == ST_DISCARD);
    assign timeout = TMO_EN && active && !rx_valid && (timer_q == LIMIT_M1);

    always_comb begin
        timer_d = '0;
        if (TMO_EN && active && !rx_valid) timer_d = timer_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= timer_d;
    end

    assign hex     = is_hex(rx_data);
    assign nib     = hex_val(rx_data);
    assign term    = is_term(rx_data);
    assign sp      = (rx_data == ASCII_SP);
    assign cnt_ok  = (cnt_q < 4'd8);
    assign has_dig = (cnt_q != 4'd0);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        vld_d   = vld_q;
        bad     = 1'b0;

        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == ASCII_W_UC || rx_data == ASCII_W_LC) begin
                        state_d = ST_SEP1;
                        wr_d    = 1'b1;
                    end else if (rx_data == ASCII_R_UC || rx_data == ASCII_R_LC) begin
                        state_d = ST_SEP1;
                        wr_d    = 1'b0;
                    end else if (!term) begin
                        bad = 1'b1;
                    end
                end
                ST_SEP1: begin
                    if (sp) begin
                        state_d = ST_ADDR;
                        addr_d  = '0;
                        data_d  = '0;
                        cnt_d   = '0;
                    end else bad = 1'b1;
                end
                ST_ADDR: begin
                    if (hex && cnt_ok) begin
                        addr_d = {addr_q[27:0], nib};
                        cnt_d  = cnt_q + 4'd1;
                    end else if (sp && wr_q && has_dig) begin
                        state_d = ST_SEP2;
                    end else if (term && !wr_q && has_dig) begin
                        state_d = ST_ISSUE;
                        vld_d   = 1'b1;
                    end else bad = 1'b1;
                end
                ST_SEP2: begin
                    if (hex) begin
                        state_d = ST_DATA;
                        data_d  = {28'd0, nib};
                        cnt_d   = 4'd1;
                    end else bad = 1'b1;
                end
                ST_DATA: begin
                    if (hex && cnt_ok) begin
                        data_d = {data_q[27:0], nib};
                        cnt_d  = cnt_q + 4'd1;
                    end else if (term && has_dig) begin
                        state_d = ST_ISSUE;
                        vld_d   = 1'b1;
                    end else bad = 1'b1;
                end
                ST_ISSUE:   err_d = 1'b1;
                ST_DISCARD: if (term) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end

        // A terminator that breaks the grammar already ends the line, so no discard.
        if (bad) begin
            err_d   = 1'b1;
            state_d = term ? ST_IDLE : ST_DISCARD;
        end

        if (state_q == ST_ISSUE && vld_q && cmd.cmd_ready) begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
        end

        if (timeout) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign cmd.cmd_valid = vld_q;
    assign cmd.cmd_write = vld_q & wr_q;
    assign cmd.cmd_addr  = vld_q ? addr_q : 32'd0;
    assign cmd.cmd_wdata = (vld_q && wr_q) ? data_q : 32'd0;
    assign err           = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a line-level grammar model checked every cycle,
// plus literal expectations for each scenario.
module tb_uart_cmd_parser;

    localparam int CLK_FREQ   = 1;
    localparam int TIMEOUT_MS = 1;
    localparam int LIMIT      = CLK_FREQ * 1000 * TIMEOUT_MS;
    localparam byte unsigned CR = 8'h0D;
    localparam byte unsigned LF = 8'h0A;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       err, busy;

    uart_cmd_parser_if cmd_if();

    uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd      (cmd_if),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line-level model ----------------
    function automatic int nib_of(input byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic bit is_t(input byte unsigned c);
        return (c == CR) || (c == LF);
    endfunction

    // Judges a whole line prefix: 0 = still valid, 1 = malformed, 2 = complete command.
    function automatic int classify(input byte unsigned l[$], output bit wr,
                                    output logic [31:0] a, output logic [31:0] d);
        int n, i, cnt;
        n = l.size(); a = 0; d = 0; wr = 0;
        if (!(l[0] == "W" || l[0] == "w" || l[0] == "R" || l[0] == "r")) return 1;
        wr = (l[0] == "W" || l[0] == "w");
        if (n == 1) return 0;
        if (l[1] != " ") return 1;
        i = 2; cnt = 0;
        while (i < n && nib_of(l[i]) >= 0) begin
            a = a * 16 + 32'(nib_of(l[i])); cnt++; i++;
        end
        if (cnt > 8) return 1;
        if (i == n) return 0;
        if (!wr) return (is_t(l[i]) && cnt >= 1) ? 2 : 1;
        if (l[i] != " " || cnt == 0) return 1;
        i++; cnt = 0;
        while (i < n && nib_of(l[i]) >= 0) begin
            d = d * 16 + 32'(nib_of(l[i])); cnt++; i++;
        end
        if (cnt > 8) return 1;
        if (i == n) return 0;
        return (is_t(l[i]) && cnt >= 1) ? 2 : 1;
    endfunction

    byte unsigned line[$];
    bit          disc_m, pend_m, m_err, m_wr, c_wr;
    logic [31:0] m_addr, m_data, c_a, c_d;
    int          tmr, c_r;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            line.delete(); disc_m = 0; pend_m = 0; m_err = 0; tmr = 0;
            m_wr = 0; m_addr = 0; m_data = 0;
        end else begin
            m_err = 0;
            if (pend_m) begin
                if (rx_valid) m_err = 1;
                if (cmd_if.cmd_ready) pend_m = 0;
                tmr = 0;
            end else if (rx_valid) begin
                tmr = 0;
                if (disc_m) begin
                    if (is_t(rx_data)) disc_m = 0;
                end else if (!(line.size() == 0 && is_t(rx_data))) begin
                    line.push_back(rx_data);
                    c_r = classify(line, c_wr, c_a, c_d);
                    if (c_r == 1) begin
                        m_err = 1; line.delete(); disc_m = !is_t(rx_data);
                    end else if (c_r == 2) begin
                        pend_m = 1; m_wr = c_wr; m_addr = c_a; m_data = c_wr ? c_d : 32'd0;
                        line.delete();
                    end
                end
            end else if (line.size() > 0 || disc_m) begin
                tmr++;
                if (tmr == LIMIT) begin
                    m_err = 1; line.delete(); disc_m = 0; tmr = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("err", {31'd0, err}, {31'd0, m_err});
        check("busy", {31'd0, busy}, {31'd0, (line.size() > 0) || disc_m || pend_m});
        check("cmd_valid", {31'd0, cmd_if.cmd_valid}, {31'd0, pend_m});
        if (pend_m) begin
            check("cmd_write", {31'd0, cmd_if.cmd_write}, {31'd0, m_wr});
            check("cmd_addr", cmd_if.cmd_addr, m_addr);
            check("cmd_wdata", cmd_if.cmd_wdata, m_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input byte unsigned b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_line(input string s, input byte unsigned t);
        send_str(s);
        send_byte(t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int found;

    initial begin
        cmd_if.cmd_ready = 1'b1;
        idle(3);
        check("rst_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", cmd_if.cmd_addr, 32'd0);
        rst = 1'b1;
        idle(2);

        // full-width write, ready already high
        send_line("W 80000010 DEADBEEF", CR);
        check("w1_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
        check("w1_write", {31'd0, cmd_if.cmd_write}, 32'd1);
        check("w1_addr", cmd_if.cmd_addr, 32'h8000_0010);
        check("w1_wdata", cmd_if.cmd_wdata, 32'hDEAD_BEEF);
        idle(1);
        check("w1_pulse", {31'd0, cmd_if.cmd_valid}, 32'd0);

        // short read with LF, then blank CR/LF lines
        send_line("r 1f", LF);
        check("r1_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
        check("r1_write", {31'd0, cmd_if.cmd_write}, 32'd0);
        check("r1_addr", cmd_if.cmd_addr, 32'h0000_001F);
        check("r1_wdata", cmd_if.cmd_wdata, 32'd0);
        idle(1);
        send_byte(CR);
        send_byte(LF);
        check("blank_busy", {31'd0, busy}, 32'd0);

        // nine address digits
        send_str("W 12345678");
        send_byte("9");
        check("ovf_err", {31'd0, err}, 32'd1);
        send_line(" 1", CR);
        check("ovf_idle", {31'd0, busy}, 32'd0);
        send_line("R 4", CR);
        check("r4_addr", cmd_if.cmd_addr, 32'h4);
        idle(2);

        // stalled consumer plus overrun byte
        cmd_if.cmd_ready = 1'b0;
        send_line("R 10", CR);
        for (int k = 0; k < 20; k++) begin
            check("stall_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
            check("stall_addr", cmd_if.cmd_addr, 32'h10);
            if (k == 6) check("overrun_err", {31'd0, err}, 32'd1);
            rx_data  = "X";
            rx_valid = (k == 5);
            @(negedge clk);
        end
        cmd_if.cmd_ready = 1'b1;
        @(negedge clk);
        check("stall_done", {31'd0, cmd_if.cmd_valid}, 32'd0);
        check("stall_idle", {31'd0, busy}, 32'd0);

        // errored terminators return straight to idle
        send_line("R", CR);
        check("rcr_err", {31'd0, err}, 32'd1);
        check("rcr_busy", {31'd0, busy}, 32'd0);
        send_line("W 10", CR);
        check("wcr_err", {31'd0, err}, 32'd1);
        check("wcr_busy", {31'd0, busy}, 32'd0);
        send_line("w aB 0", LF);
        check("wab_addr", cmd_if.cmd_addr, 32'hAB);
        check("wab_wdata", cmd_if.cmd_wdata, 32'h0);
        idle(2);

        // timeout of a partial line
        send_str("W 10");
        check("tmo_busy0", {31'd0, busy}, 32'd1);
        found = 0;
        for (int k = 1; k <= LIMIT + 20; k++) begin
            @(negedge clk);
            if (err && found == 0) found = k;
        end
        check("tmo_cycle", found, LIMIT);
        check("tmo_busy1", {31'd0, busy}, 32'd0);

        // asynchronous reset while a request is pending
        cmd_if.cmd_ready = 1'b0;
        send_line("R 5", CR);
        check("pre_rst_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
        #2 rst = 1'b0;
        #1 check("async_rst_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        idle(1);
        send_line("R 0", CR);
        check("r0_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
        check("r0_addr", cmd_if.cmd_addr, 32'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Host-to-core debug command path. It takes the received byte stream from the UART receiver (ASCII lines typed by the host), parses read and write commands with hex operands, and issues one memory/debug-bus request per line over a valid/ready handshake. It is the inbound counterpart of the outbound error logger: the logger emits ASCII hex to the host, and this block accepts ASCII hex from it.

Parameters:
CLK_FREQ, 27, system clock in MHz. Used only to scale the timeout.
TIMEOUT_MS, 100, abort a partially received line after this many ms with no new byte. 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe per received byte; no backpressure
cmd_valid  out  1  request pending
cmd_ready  in  1  consumer accepts the request when cmd_valid && cmd_ready
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  32  request address
cmd_wdata  out  32  write data; 0 for reads
err  out  1  one-cycle pulse on a malformed line, an overrun or a timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Grammar, one command per line:
  - Write: "W" or "w", one space, 1-8 hex digits (address), one space, 1-8 hex digits (data), terminator.
  - Read: "R" or "r", one space, 1-8 hex digits (address), terminator.
- Terminator is CR (0x0D) or LF (0x0A).
- Hex digits are 0-9, A-F and a-f. Fewer than 8 digits are zero-extended on the left.
- States: IDLE, SEP1, ADDR, SEP2, DATA, ISSUE, DISCARD.
- Field accumulation on each digit: field <= {field[27:0], nibble}; digit count increments (4-bit, 0..8).
- Transitions, evaluated only on cycles with rx_valid:
  - IDLE: W/w -> SEP1 with wr=1; R/r -> SEP1 with wr=0; CR/LF ignored (empty line, no err, so CRLF works); any other byte -> err, DISCARD.
  - SEP1: space -> ADDR with addr=0, count=0; otherwise -> err, DISCARD.
  - ADDR:
    - hex digit with count<8 -> accumulate;
    - hex digit with count==8 -> err, DISCARD;
    - space, wr=1, count>=1 -> SEP2;
    - terminator, wr=0, count>=1 -> ISSUE;
    - anything else -> err, DISCARD.
  - SEP2: hex digit -> DATA, loading that digit as the first nibble (count=1); otherwise -> err, DISCARD.
  - DATA:
    - hex digit with count<8 -> accumulate;
    - terminator with count>=1 -> ISSUE;
    - anything else, or a 9th digit -> err, DISCARD.
  - DISCARD: terminator -> IDLE; other bytes dropped without further err.
- Errored terminator: a terminator byte that itself causes the error (for example "R\r", or "W 10\r" with wr=1) goes to IDLE, not DISCARD, with err pulsed.
- ISSUE:
  - cmd_valid is registered high in the cycle after entry.
  - cmd_write, cmd_addr and cmd_wdata are stable while cmd_valid is high.
  - On cmd_valid && cmd_ready, cmd_valid drops the next cycle and the state returns to IDLE.
  - Latency: terminator strobe at cycle N -> cmd_valid high at N+1. A ready that is already high completes the handshake at N+1.
- Overrun: rx_valid while in ISSUE drops the byte and pulses err. The pending command is unaffected.
- Timeout:
  - Counter limit = CLK_FREQ*1000*TIMEOUT_MS cycles.
  - The counter clears on every rx_valid and runs in SEP1, ADDR, SEP2, DATA and DISCARD.
  - Reaching the limit -> err pulse, state to IDLE.
  - Not active in IDLE or ISSUE.
- Err pulse: err is registered, exactly one cycle per event. Simultaneous causes produce a single pulse.
- Reset values: every output 0; state IDLE; fields, counts and timer 0.
- Reset asserted mid-line or during ISSUE drops the line and deasserts cmd_valid immediately (asynchronous).

Decomposition:
- Package uart_cmd_pkg:
  - state encoding;
  - ASCII constants (CR, LF, SPACE, 'W', 'w', 'R', 'r');
  - function is_hex(byte) and function hex_val(byte) returning a 4-bit nibble, the inverse of the logger's hex encoder.
- No sub-module. The timeout counter and the FSM are one always block each, plus registered outputs.

Test Plan:
- "W 80000010 DEADBEEF\r" with cmd_ready=1 -> a single cmd_valid pulse one cycle after CR; write=1, addr=0x80000010, wdata=0xDEADBEEF; err stays 0.
- "r 1f\n" then "\r\n" -> one read, addr=0x0000001F, wdata=0; the blank CR/LF lines produce nothing.
- "W 123456789 1\r" (9 address digits) -> err pulse on the 9th digit; no cmd_valid; next line "R 4\r" issues addr=0x4.
- "R 10\r" with cmd_ready held 0 for 20 cycles while byte 'X' arrives -> cmd_valid and addr=0x10 stable for 20 cycles, err pulse on 'X', handshake completes when ready rises.
- "W 10" then silence for the timeout, with TIMEOUT_MS=1 and CLK_FREQ=1 (limit 1000 cycles) -> err at cycle 1000 after the last byte, busy falls, no cmd_valid.
- rst asserted during ISSUE -> cmd_valid 0 asynchronously; after release, "R 0\r" issues normally.
